// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - serial transmitter with input FIFO, configurable data and stop bits

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_tdata,
  input  logic             wr_tvalid,
  output logic             wr_tready,
  output logic [WIDTH-1:0] rd_tdata,
  output logic             rd_tvalid,
  input  logic             rd_tready,
  output logic             empty_next
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push, pop;

  // Ready reflects only the registered occupancy; a same-cycle pop never raises it.
  assign wr_tready = (count_q != FULL_COUNT);
  assign rd_tvalid = (count_q != '0);
  assign rd_tdata  = mem_q[rd_ptr_q];
  assign push      = wr_tvalid && wr_tready;
  assign pop       = rd_tready && rd_tvalid;

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_tdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    empty_next = (count_d == '0);
  end

  // Storage needs no reset; pointers and occupancy clear synchronously.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module uart_tx #(
  parameter int CLOCK_HZ    = 27000000,
  parameter int BIT_RATE_HZ = 115200,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);
  localparam int BIT_CYCLES = CLOCK_HZ / BIT_RATE_HZ;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [2:0]           bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic [DATA_BITS-1:0] fifo_tdata;
  logic                 fifo_tvalid;
  logic                 fifo_pop;
  logic                 fifo_empty_next;
  logic                 cyc_last;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_tdata   (tx_data),
    .wr_tvalid  (tx_valid),
    .wr_tready  (tx_ready),
    .rd_tdata   (fifo_tdata),
    .rd_tvalid  (fifo_tvalid),
    .rd_tready  (fifo_pop),
    .empty_next (fifo_empty_next)
  );

  assign cyc_last = (cyc_q == CYC_LAST);
  assign tx       = tx_q;
  assign busy     = busy_q;

  // Frame sequencer: start bit, LSB-first data, stop bits, chaining queued words with no gap.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bitn_d   = bitn_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (fifo_tvalid) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_tdata;
          tx_d     = 1'b0;
          cyc_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (cyc_last) begin
          cyc_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bitn_d  = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cyc_last) begin
          cyc_d = '0;
          if (bitn_q == DATA_LAST) begin
            tx_d    = 1'b1;
            bitn_d  = '0;
            state_d = S_STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bitn_d  = bitn_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        // Stop phase: bitn counts completed stop bits.
        if (cyc_last) begin
          cyc_d = '0;
          if (bitn_q == STOP_LAST) begin
            bitn_d = '0;
            if (fifo_tvalid) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_tdata;
              tx_d     = 1'b0;
              state_d  = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
    endcase
  end

  // Busy is the registered image of "not idle or words still queued".
  always_comb begin
    busy_d = (state_d != S_IDLE) || !fifo_empty_next;
  end

  // State registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized bench for uart_tx against a frame-schedule model
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int BC    = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [6:0] tx_data2 = '0;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx2, busy2;

  int sel = 0;
  int dbits = 8;
  int sbits = 1;
  int cnt = 0;
  int checks = 0;
  int errors = 0;

  logic o_tx, o_ready, o_busy;
  assign o_tx    = (sel == 1) ? tx2 : tx;
  assign o_ready = (sel == 1) ? tx_ready2 : tx_ready;
  assign o_busy  = (sel == 1) ? busy2 : busy;

  uart_tx #(.CLOCK_HZ(16), .BIT_RATE_HZ(1), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy));

  uart_tx #(.CLOCK_HZ(16), .BIT_RATE_HZ(1), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  // Reference model: each accepted word owns a frame window [start, start+len).
  int         acc_q[$];
  int         start_q[$];
  logic [7:0] word_q[$];
  int         last_end = 0;
  logic [7:0] rx_q[$];

  function automatic int flen();
    return (1 + dbits + sbits) * BC;
  endfunction

  function automatic logic exp_tx(input int e);
    int o;
    logic [7:0] w;
    for (int i = 0; i < word_q.size(); i++) begin
      if (e >= start_q[i] && e < start_q[i] + flen()) begin
        o = (e - start_q[i]) / BC;
        w = word_q[i];
        if (o == 0) return 1'b0;
        if (o <= dbits) return w[o-1];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic int exp_occ(input int e);
    int n = 0;
    for (int i = 0; i < acc_q.size(); i++) begin
      if (acc_q[i] <= e) n++;
      if (start_q[i] <= e) n--;
    end
    return n;
  endfunction

  function automatic logic exp_ready(input int e);
    return (exp_occ(e) < DEPTH);
  endfunction

  function automatic logic exp_busy(input int e);
    return (exp_occ(e) > 0) || (e < last_end);
  endfunction

  // Drive inputs for the coming edge and record what the model says it accepts.
  task automatic drive(input logic v, input logic [7:0] d, input logic r, output logic acc);
    int e, st;
    acc       = 1'b0;
    reset     = r;
    tx_valid  = (sel == 0) ? v : 1'b0;
    tx_data   = d;
    tx_valid2 = (sel == 1) ? v : 1'b0;
    tx_data2  = d[6:0];
    if (r) begin
      acc_q.delete(); start_q.delete(); word_q.delete(); last_end = 0;
    end else if (v && exp_ready(cnt)) begin
      e  = cnt + 1;
      st = (last_end > e + 1) ? last_end : e + 1;
      acc_q.push_back(e);
      start_q.push_back(st);
      word_q.push_back((sel == 1) ? {1'b0, d[6:0]} : d);
      last_end = st + flen();
      acc = 1'b1;
    end
  endtask

  // Mid-bit line sampler, independent of the cycle model.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (o_tx === 1'b0) begin
        repeat (BC/2) @(negedge clk);
        if (o_tx === 1'b0) begin
          b = '0;
          for (int i = 0; i < dbits; i++) begin
            repeat (BC) @(negedge clk);
            b[i] = o_tx;
          end
          repeat (BC) @(negedge clk);
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic test_reset();
    logic a;
    @(negedge clk); drive(1'b0, 8'h00, 1'b1, a);
    @(negedge clk); drive(1'b0, 8'h00, 1'b1, a);
    @(negedge clk);
    checks += 3;
    if (o_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", o_tx); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    drive(1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic test_single();
    logic a;
    int n_acc = -1000;
    rx_q.delete();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      checks += 3;
      if (o_tx !== exp_tx(cnt)) begin errors++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", cnt, o_tx, exp_tx(cnt)); end
      if (o_ready !== exp_ready(cnt)) begin errors++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", cnt, o_ready, exp_ready(cnt)); end
      if (o_busy !== exp_busy(cnt)) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cnt, o_busy, exp_busy(cnt)); end
      if (cnt == n_acc + 1) begin
        checks++;
        if (o_tx !== 1'b0) begin errors++; $display("FAIL single_latency got=%b exp=0", o_tx); end
      end
      if (cnt == n_acc + 161) begin
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", o_busy); end
      end
      drive(c == 0, 8'h41, 1'b0, a);
      if (a) n_acc = cnt + 1;
    end
    checks += 2;
    if (n_acc < 0) begin errors++; $display("FAIL single_accept got=none exp=accepted"); end
    if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin
      errors++; $display("FAIL single_decode got_n=%0d first=%h exp=41", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic a;
    logic [7:0] seq [5];
    int idx = 0;
    logic saw_full = 1'b0;
    seq = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33};
    rx_q.delete();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks += 3;
      if (o_tx !== exp_tx(cnt)) begin errors++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", cnt, o_tx, exp_tx(cnt)); end
      if (o_ready !== exp_ready(cnt)) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cnt, o_ready, exp_ready(cnt)); end
      if (o_busy !== exp_busy(cnt)) begin errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cnt, o_busy, exp_busy(cnt)); end
      if (o_ready === 1'b0) saw_full = 1'b1;
      drive(idx < 5, seq[(idx < 5) ? idx : 0], 1'b0, a);
      if (a) idx++;
    end
    checks += 3;
    if (idx != 5) begin errors++; $display("FAIL b2b_accepts got=%0d exp=5", idx); end
    if (saw_full !== 1'b1) begin errors++; $display("FAIL b2b_full got=%b exp=1", saw_full); end
    if (rx_q.size() != 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== seq[i]) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, rx_q[i], seq[i]); end
    end
  endtask

  task automatic test_full_ignored();
    logic a;
    logic [7:0] w;
    logic [7:0] sent[$];
    int phase = 0;
    int held = 0;
    rx_q.delete();
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      checks += 3;
      if (o_tx !== exp_tx(cnt)) begin errors++; $display("FAIL full_tx cyc=%0d got=%b exp=%b", cnt, o_tx, exp_tx(cnt)); end
      if (o_ready !== exp_ready(cnt)) begin errors++; $display("FAIL full_ready cyc=%0d got=%b exp=%b", cnt, o_ready, exp_ready(cnt)); end
      if (o_busy !== exp_busy(cnt)) begin errors++; $display("FAIL full_busy cyc=%0d got=%b exp=%b", cnt, o_busy, exp_busy(cnt)); end
      if (phase == 0) begin
        w = 8'($urandom_range(0, 255));
        if (w == 8'h99) w = 8'h98;
        drive(1'b1, w, 1'b0, a);
        if (a) sent.push_back(w);
        if (sent.size() == 5) phase = 1;
      end else if (phase == 1 && !exp_ready(cnt)) begin
        drive(1'b1, 8'h99, 1'b0, a);
        held++;
      end else begin
        phase = 2;
        drive(1'b0, 8'h00, 1'b0, a);
      end
    end
    checks += 2;
    if (held < 100) begin errors++; $display("FAIL full_hold got=%0d exp>=100", held); end
    if (rx_q.size() != 5) begin errors++; $display("FAIL full_count got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== sent[i]) begin errors++; $display("FAIL full_byte%0d got=%h exp=%h", i, rx_q[i], sent[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    int target = -1000;
    int rc = -1000;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks += 3;
      if (o_tx !== exp_tx(cnt)) begin errors++; $display("FAIL rmid_tx cyc=%0d got=%b exp=%b", cnt, o_tx, exp_tx(cnt)); end
      if (o_ready !== exp_ready(cnt)) begin errors++; $display("FAIL rmid_ready cyc=%0d got=%b exp=%b", cnt, o_ready, exp_ready(cnt)); end
      if (o_busy !== exp_busy(cnt)) begin errors++; $display("FAIL rmid_busy cyc=%0d got=%b exp=%b", cnt, o_busy, exp_busy(cnt)); end
      if (c == rc + 1) begin
        checks += 3;
        if (o_tx !== 1'b1) begin errors++; $display("FAIL rmid_tx_after got=%b exp=1", o_tx); end
        if (o_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after got=%b exp=1", o_ready); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_after got=%b exp=0", o_busy); end
      end
      if (c < 3) begin
        drive(1'b1, (c == 0) ? 8'hC3 : 8'($urandom_range(0, 255)), 1'b0, a);
        if (c == 0 && a) target = start_q[start_q.size()-1] + 4*BC + 8;
      end else if (cnt == target) begin
        drive(1'b0, 8'h00, 1'b1, a);
        rc = c;
      end else begin
        drive(1'b0, 8'h00, 1'b0, a);
      end
    end
    checks++;
    if (rc < 0) begin errors++; $display("FAIL rmid_reached got=none exp=reset_applied"); end
  endtask

  task automatic test_same_edge();
    logic a;
    logic [7:0] ab [6];
    int n = 0;
    int pe = 1 << 30;
    for (int i = 0; i < 6; i++) ab[i] = 8'($urandom_range(0, 255));
    rx_q.delete();
    for (int c = 0; c < 1300; c++) begin
      @(negedge clk);
      checks += 3;
      if (o_tx !== exp_tx(cnt)) begin errors++; $display("FAIL same_tx cyc=%0d got=%b exp=%b", cnt, o_tx, exp_tx(cnt)); end
      if (o_ready !== exp_ready(cnt)) begin errors++; $display("FAIL same_ready cyc=%0d got=%b exp=%b", cnt, o_ready, exp_ready(cnt)); end
      if (o_busy !== exp_busy(cnt)) begin errors++; $display("FAIL same_busy cyc=%0d got=%b exp=%b", cnt, o_busy, exp_busy(cnt)); end
      if (cnt == pe) begin
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL same_ready_pop got=%b exp=1", o_ready); end
      end
      if (n < 3) begin
        drive(1'b1, ab[n], 1'b0, a);
        if (a) begin
          if (n == 0) pe = start_q[start_q.size()-1] + flen();
          n++;
        end
      end else if (n < 6 && cnt >= pe - 1) begin
        drive(1'b1, ab[n], 1'b0, a);
        if (a) n++;
      end else begin
        drive(1'b0, 8'h00, 1'b0, a);
      end
    end
    checks += 2;
    if (n != 6) begin errors++; $display("FAIL same_accepts got=%0d exp=6", n); end
    if (rx_q.size() != 6) begin errors++; $display("FAIL same_count got=%0d exp=6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== ab[i]) begin errors++; $display("FAIL same_byte%0d got=%h exp=%h", i, rx_q[i], ab[i]); end
    end
  endtask

  task automatic test_7n2();
    logic a;
    logic prev = 1'b1;
    int falls[$];
    sel = 1; dbits = 7; sbits = 2;
    @(negedge clk); drive(1'b0, 8'h00, 1'b1, a);
    rx_q.delete();
    for (int c = 0; c < 450; c++) begin
      @(negedge clk);
      checks += 3;
      if (o_tx !== exp_tx(cnt)) begin errors++; $display("FAIL n72_tx cyc=%0d got=%b exp=%b", cnt, o_tx, exp_tx(cnt)); end
      if (o_ready !== exp_ready(cnt)) begin errors++; $display("FAIL n72_ready cyc=%0d got=%b exp=%b", cnt, o_ready, exp_ready(cnt)); end
      if (o_busy !== exp_busy(cnt)) begin errors++; $display("FAIL n72_busy cyc=%0d got=%b exp=%b", cnt, o_busy, exp_busy(cnt)); end
      if (prev === 1'b1 && o_tx === 1'b0) falls.push_back(cnt);
      prev = o_tx;
      drive(c < 2, (c == 0) ? 8'h7F : 8'h00, 1'b0, a);
    end
    checks += 3;
    if (falls.size() != 2) begin errors++; $display("FAIL n72_starts got=%0d exp=2", falls.size()); end
    else if (falls[1] - falls[0] != 160) begin errors++; $display("FAIL n72_period got=%0d exp=160", falls[1] - falls[0]); end
    if (rx_q.size() != 2) begin errors++; $display("FAIL n72_count got=%0d exp=2", rx_q.size()); end
    else if (rx_q[0] !== 8'h7F || rx_q[1] !== 8'h00) begin
      errors++; $display("FAIL n72_bytes got=%h,%h exp=7f,00", rx_q[0], rx_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_ignored();
    test_reset_mid();
    test_same_edge();
    test_7n2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
